// File: rtl/tpg_mode_ctrl.sv
// Mode controller for the test pattern generator: shadow/active timing banks,
// commit validation, vsync-aligned apply and a post-apply generator reset window.
module tpg_mode_ctrl #(
    parameter int H_BITS     = 12,
    parameter int V_BITS     = 12,
    parameter int RST_CYCLES = 4,
    parameter int TO_BITS    = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [15:0]       wr_data,
    input  logic              commit,
    input  logic              vs_in,
    output logic              busy,
    output logic              cfg_err,
    output logic              applied,
    output logic              tpg_rst_n,
    output logic [H_BITS-1:0] t_hs_start,
    output logic [H_BITS-1:0] t_hs_end,
    output logic [H_BITS-1:0] t_hact_start,
    output logic [H_BITS-1:0] t_hact_end,
    output logic [H_BITS-1:0] t_h_end,
    output logic [V_BITS-1:0] t_vs_start,
    output logic [V_BITS-1:0] t_vs_end,
    output logic [V_BITS-1:0] t_vact_start,
    output logic [V_BITS-1:0] t_vact_end,
    output logic [V_BITS-1:0] t_v_end
);
    localparam int HC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    // Bank slot order: sync start, sync end, active start, active end, total end.
    localparam logic [H_BITS-1:0] H_DEF [5] = '{H_BITS'(656), H_BITS'(752), H_BITS'(0),
                                                 H_BITS'(640), H_BITS'(800)};
    localparam logic [V_BITS-1:0] V_DEF [5] = '{V_BITS'(490), V_BITS'(492), V_BITS'(0),
                                                 V_BITS'(480), V_BITS'(525)};

    typedef enum logic [1:0] {S_IDLE, S_WAIT_VS, S_HOLD} state_t;

    state_t             state_q, state_d;
    logic [HC_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [TO_BITS-1:0] to_cnt_q, to_cnt_d, to_inc;
    logic               vs_prev_q;
    logic               pend_q, pend_d;
    logic               busy_q, busy_d;
    logic               cfg_err_q, cfg_err_d;
    logic               applied_q, applied_d;
    logic               tpg_rst_n_q, tpg_rst_n_d;
    logic               load_act;

    logic [H_BITS-1:0]  h_sh_q [5];
    logic [V_BITS-1:0]  v_sh_q [5];
    logic [H_BITS-1:0]  h_act_q [5];
    logic [V_BITS-1:0]  v_act_q [5];

    logic               vs_rise, timeout, hold_done;
    logic               wr_ok, commit_ok, bank_valid, h_valid, v_valid;
    logic [2:0]         v_idx;
    logic               unused_wr;

    assign unused_wr = &{1'b0, wr_data};

    assign vs_rise   = vs_in & ~vs_prev_q;
    assign to_inc    = to_cnt_q + TO_BITS'(1);
    assign timeout   = &to_inc;
    assign hold_done = (hold_cnt_q == HC_W'(RST_CYCLES - 1));
    assign wr_ok     = wr_en & (state_q == S_IDLE);
    assign commit_ok = commit & ~wr_en & (state_q == S_IDLE);
    assign v_idx     = 3'(wr_addr - 4'd5);

    assign h_valid = (h_sh_q[0] < h_sh_q[1]) && (h_sh_q[1] < h_sh_q[4]) &&
                     (h_sh_q[2] < h_sh_q[3]) && (h_sh_q[3] <= h_sh_q[4]) &&
                     (h_sh_q[4] >= H_BITS'(2));
    assign v_valid = (v_sh_q[0] < v_sh_q[1]) && (v_sh_q[1] < v_sh_q[4]) &&
                     (v_sh_q[2] < v_sh_q[3]) && (v_sh_q[3] <= v_sh_q[4]) &&
                     (v_sh_q[4] >= V_BITS'(2));
    assign bank_valid = h_valid & v_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_HOLD;
            hold_cnt_q  <= '0;
            to_cnt_q    <= '0;
            vs_prev_q   <= 1'b0;
            pend_q      <= 1'b0;
            busy_q      <= 1'b1;
            cfg_err_q   <= 1'b0;
            applied_q   <= 1'b0;
            tpg_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            to_cnt_q    <= to_cnt_d;
            vs_prev_q   <= vs_in;
            pend_q      <= pend_d;
            busy_q      <= busy_d;
            cfg_err_q   <= cfg_err_d;
            applied_q   <= applied_d;
            tpg_rst_n_q <= tpg_rst_n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (commit_ok && bank_valid) state_d = S_WAIT_VS;
            S_WAIT_VS: if (vs_rise || timeout)      state_d = S_HOLD;
            S_HOLD:    if (hold_done)               state_d = S_IDLE;
            default:                                state_d = S_HOLD;
        endcase
    end

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        to_cnt_d   = to_cnt_q;
        cfg_err_d  = cfg_err_q;
        pend_d     = pend_q;
        applied_d  = 1'b0;
        load_act   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (commit_ok) begin
                    cfg_err_d = ~bank_valid;
                    to_cnt_d  = '0;
                end
            end
            S_WAIT_VS: begin
                to_cnt_d = to_inc;
                if (state_d == S_HOLD) begin
                    load_act   = 1'b1;
                    hold_cnt_d = '0;
                    pend_d     = 1'b1;
                end
            end
            S_HOLD: begin
                hold_cnt_d = hold_cnt_q + HC_W'(1);
                // Startup release leaves pend_q clear, so only commits pulse applied.
                if (hold_done) begin
                    applied_d = pend_q;
                    pend_d    = 1'b0;
                end
            end
            default: ;
        endcase
        busy_d      = (state_d != S_IDLE);
        tpg_rst_n_d = (state_d != S_HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) begin
                h_sh_q[i]  <= H_DEF[i];
                v_sh_q[i]  <= V_DEF[i];
                h_act_q[i] <= H_DEF[i];
                v_act_q[i] <= V_DEF[i];
            end
        end else begin
            if (wr_ok) begin
                if (wr_addr < 4'd5) begin
                    h_sh_q[wr_addr[2:0]] <= wr_data[H_BITS-1:0];
                end else if (wr_addr < 4'd10) begin
                    v_sh_q[v_idx] <= wr_data[V_BITS-1:0];
                end
            end
            if (load_act) begin
                h_act_q <= h_sh_q;
                v_act_q <= v_sh_q;
            end
        end
    end

    assign busy         = busy_q;
    assign cfg_err      = cfg_err_q;
    assign applied      = applied_q;
    assign tpg_rst_n    = tpg_rst_n_q;
    assign t_hs_start   = h_act_q[0];
    assign t_hs_end     = h_act_q[1];
    assign t_hact_start = h_act_q[2];
    assign t_hact_end   = h_act_q[3];
    assign t_h_end      = h_act_q[4];
    assign t_vs_start   = v_act_q[0];
    assign t_vs_end     = v_act_q[1];
    assign t_vact_start = v_act_q[2];
    assign t_vact_end   = v_act_q[3];
    assign t_v_end      = v_act_q[4];

endmodule
